// File: rtl/nq_pkg.sv
// Shared encodings, FSM states and the decode->execute pipeline bundle for the NanoQuarter core.
package nq_pkg;

    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_I  = 2'b01;
    localparam logic [1:0] OP_BR = 2'b10;
    localparam logic [1:0] OP_J  = 2'b11;

    localparam logic [2:0] F_LD  = 3'b010;
    localparam logic [2:0] F_ST  = 3'b011;
    localparam logic [2:0] F_JR  = 3'b001;
    localparam logic [2:0] F_BNE = 3'b001;

    localparam logic [1:0] BUB_OP    = 2'b11;
    localparam logic [2:0] BUB_FUNCT = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    typedef struct packed {
        logic [15:0] reg1data;
        logic [15:0] reg2data;
        logic [7:0]  jtarget;
        logic [7:0]  idata;
        logic [5:0]  memaddr;
        logic [4:0]  boffset;
        logic [2:0]  funct;
        logic [1:0]  op;
        logic [1:0]  shamt;
        logic [2:0]  rd;
        logic        bne;
        logic        jr;
        logic        jmp;
        logic        memread;
        logic        memwrite;
        logic        memselect;
        logic        memenable;
        logic        datamemwrite;
        logic        valid;
    } bundle_t;

    // A J-type with funct 111 never writes a register downstream, so it is a safe no-op.
    function automatic bundle_t bubble_bundle();
        bundle_t b;
        b       = '0;
        b.op    = BUB_OP;
        b.funct = BUB_FUNCT;
        return b;
    endfunction

endpackage

// File: rtl/nq_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module nq_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [15:0]   rdata1,
    output logic [15:0]   rdata2,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata
);

    logic [15:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Writeback in the same cycle as the read is forwarded so decode never sees stale data.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (wen && waddr == raddr1) begin
            rdata1 = wdata;
        end

        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (wen && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/nq_decode_stage.sv
// NanoQuarter decode stage: field decode, register read, APB SETUP/ACCESS sequencing and the
// registered bundle consumed by execute/memory.
module nq_decode_stage
    import nq_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int PCW   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    instr_in,
    input  logic [PCW-1:0] pc_in,
    input  logic           ivalid_in,
    input  logic           flush_in,
    input  logic           wb_en,
    input  logic [2:0]     wb_addr,
    input  logic [15:0]    wb_data,
    output logic           stall_out,
    output logic [15:0]    reg1data_out,
    output logic [15:0]    reg2data_out,
    output logic [7:0]     jtarget_out,
    output logic [7:0]     idata_out,
    output logic [5:0]     memaddr_out,
    output logic [4:0]     boffset_out,
    output logic [2:0]     funct_out,
    output logic [1:0]     op_out,
    output logic [1:0]     shamt_out,
    output logic [2:0]     rd_out,
    output logic           bne_out,
    output logic           jr_out,
    output logic           jmp_out,
    output logic           memread_out,
    output logic           memwrite_out,
    output logic           memselect_out,
    output logic           memenable_out,
    output logic           datamemwrite_out,
    output logic [PCW-1:0] pc_out,
    output logic           valid_out
);

    state_t         state;
    bundle_t        bundle_q;
    bundle_t        dec;
    bundle_t        nxt;
    logic [PCW-1:0] pc_q;
    logic [2:0]     rs_idx;
    logic [2:0]     rt_idx;
    logic [15:0]    rs_data;
    logic [15:0]    rt_data;
    logic           is_mem;
    logic           accept;

    nq_regfile #(
        .NREGS(NREGS),
        .AW   (3)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .raddr1(rs_idx),
        .raddr2(rt_idx),
        .rdata1(rs_data),
        .rdata2(rt_data),
        .wen   (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data)
    );

    // Fields not defined for the current op stay zero; unused read ports address r0.
    always_comb begin
        dec    = '0;
        rs_idx = '0;
        rt_idx = '0;
        dec.op    = instr_in[15:14];
        dec.valid = 1'b1;
        case (instr_in[15:14])
            OP_R: begin
                dec.rd    = instr_in[13:11];
                rs_idx    = instr_in[13:11];
                rt_idx    = instr_in[10:8];
                dec.funct = instr_in[4:2];
                dec.shamt = instr_in[1:0];
            end
            OP_I: begin
                dec.rd    = instr_in[13:11];
                rs_idx    = instr_in[13:11];
                dec.funct = instr_in[10:8];
                dec.idata = instr_in[7:0];
                if (instr_in[10:8] == F_LD) begin
                    dec.memread = 1'b1;
                    dec.memaddr = instr_in[5:0];
                end
                if (instr_in[10:8] == F_ST) begin
                    dec.memwrite = 1'b1;
                    dec.memaddr  = instr_in[5:0];
                end
            end
            OP_BR: begin
                rs_idx      = instr_in[13:11];
                rt_idx      = instr_in[10:8];
                dec.funct   = instr_in[7:5];
                dec.boffset = instr_in[4:0];
                dec.bne     = (instr_in[7:5] == F_BNE);
            end
            default: begin
                dec.funct   = instr_in[13:11];
                rs_idx      = instr_in[10:8];
                dec.jtarget = instr_in[7:0];
                dec.jmp     = 1'b1;
                dec.jr      = (instr_in[13:11] == F_JR);
            end
        endcase
        dec.reg1data = rs_data;
        dec.reg2data = rt_data;
    end

    assign is_mem = dec.memread | dec.memwrite;
    assign accept = ivalid_in & ~flush_in;

    always_comb begin
        nxt              = dec;
        nxt.memselect    = is_mem;
        nxt.memenable    = 1'b0;
        nxt.datamemwrite = dec.memwrite;
    end

    assign stall_out = rst & ((state == ST_SETUP) | ((state == ST_RUN) & accept & is_mem));

    // Once a memory op leaves RUN it runs to completion; only reset can abort it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            bundle_q <= bubble_bundle();
            pc_q     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        bundle_q <= nxt;
                        pc_q     <= pc_in;
                        state    <= is_mem ? ST_SETUP : ST_RUN;
                    end else begin
                        bundle_q <= bubble_bundle();
                        pc_q     <= '0;
                    end
                end
                ST_SETUP: begin
                    bundle_q.memenable <= 1'b1;
                    state              <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign reg1data_out     = bundle_q.reg1data;
    assign reg2data_out     = bundle_q.reg2data;
    assign jtarget_out      = bundle_q.jtarget;
    assign idata_out        = bundle_q.idata;
    assign memaddr_out      = bundle_q.memaddr;
    assign boffset_out      = bundle_q.boffset;
    assign funct_out        = bundle_q.funct;
    assign op_out           = bundle_q.op;
    assign shamt_out        = bundle_q.shamt;
    assign rd_out           = bundle_q.rd;
    assign bne_out          = bundle_q.bne;
    assign jr_out           = bundle_q.jr;
    assign jmp_out          = bundle_q.jmp;
    assign memread_out      = bundle_q.memread;
    assign memwrite_out     = bundle_q.memwrite;
    assign memselect_out    = bundle_q.memselect;
    assign memenable_out    = bundle_q.memenable;
    assign datamemwrite_out = bundle_q.datamemwrite;
    assign pc_out           = pc_q;
    assign valid_out        = bundle_q.valid;

endmodule

// File: tb/tb_nq_decode_stage.sv
// Directed-vector bench for nq_decode_stage with hand-computed expected bundle values.
module tb_nq_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic [31:0] pc_in;
    logic        ivalid_in;
    logic        flush_in;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall_out;
    logic [15:0] reg1data_out, reg2data_out;
    logic [7:0]  jtarget_out, idata_out;
    logic [5:0]  memaddr_out;
    logic [4:0]  boffset_out;
    logic [2:0]  funct_out;
    logic [1:0]  op_out, shamt_out;
    logic [2:0]  rd_out;
    logic        bne_out, jr_out, jmp_out;
    logic        memread_out, memwrite_out;
    logic        memselect_out, memenable_out, datamemwrite_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int vectors     = 0;
    int miscompares = 0;

    nq_decode_stage #(.NREGS(8), .PCW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_in        (instr_in),
        .pc_in           (pc_in),
        .ivalid_in       (ivalid_in),
        .flush_in        (flush_in),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .stall_out       (stall_out),
        .reg1data_out    (reg1data_out),
        .reg2data_out    (reg2data_out),
        .jtarget_out     (jtarget_out),
        .idata_out       (idata_out),
        .memaddr_out     (memaddr_out),
        .boffset_out     (boffset_out),
        .funct_out       (funct_out),
        .op_out          (op_out),
        .shamt_out       (shamt_out),
        .rd_out          (rd_out),
        .bne_out         (bne_out),
        .jr_out          (jr_out),
        .jmp_out         (jmp_out),
        .memread_out     (memread_out),
        .memwrite_out    (memwrite_out),
        .memselect_out   (memselect_out),
        .memenable_out   (memenable_out),
        .datamemwrite_out(datamemwrite_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [31:0] pc,
                                 input logic valid, input logic flush);
        instr_in  = instr;
        pc_in     = pc;
        ivalid_in = valid;
        flush_in  = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        applyStimulus(16'h1314, 32'h100, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_op", op_out, 2'b11);
        checkOutput("rst_funct", funct_out, 3'b111);
        checkOutput("rst_pc", pc_out, 0);
        checkOutput("rst_stall", stall_out, 0);
        checkOutput("rst_memsel", memselect_out, 0);

        // After reset every register reads zero.
        rst = 1'b1;
        applyStimulus(16'h3E14, 32'h0FC, 1'b1, 1'b0);
        tick();
        checkOutput("clr_r7", reg1data_out, 0);
        checkOutput("clr_r6", reg2data_out, 0);
        checkOutput("clr_valid", valid_out, 1);
        checkOutput("clr_pc", pc_out, 32'h0FC);

        applyStimulus(16'h0000, 32'h0, 1'b0, 1'b0);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234;
        tick();
        wb_addr = 3'd3; wb_data = 16'h00FF;
        tick();
        wb_en = 1'b0;
        checkOutput("idle_bubble_valid", valid_out, 0);

        // R-type: rd 2, rt 3, funct 101.
        applyStimulus(16'h1314, 32'h104, 1'b1, 1'b0);
        checkOutput("r_stall", stall_out, 0);
        tick();
        checkOutput("r_reg1", reg1data_out, 16'h1234);
        checkOutput("r_reg2", reg2data_out, 16'h00FF);
        checkOutput("r_funct", funct_out, 3'b101);
        checkOutput("r_rd", rd_out, 3'd2);
        checkOutput("r_op", op_out, 2'b00);
        checkOutput("r_valid", valid_out, 1);
        checkOutput("r_idata", idata_out, 0);
        checkOutput("r_pc", pc_out, 32'h104);

        // Load: three-cycle APB sequence, fetch held two cycles.
        applyStimulus(16'h4A25, 32'h108, 1'b1, 1'b0);
        checkOutput("ld_stall0", stall_out, 1);
        tick();
        checkOutput("ld_sel0", memselect_out, 1);
        checkOutput("ld_en0", memenable_out, 0);
        checkOutput("ld_memread", memread_out, 1);
        checkOutput("ld_memaddr", memaddr_out, 6'h25);
        checkOutput("ld_idata", idata_out, 8'h25);
        checkOutput("ld_rd", rd_out, 3'd1);
        checkOutput("ld_funct", funct_out, 3'b010);
        checkOutput("ld_pwrite", datamemwrite_out, 0);
        checkOutput("ld_stall1", stall_out, 1);
        tick();
        checkOutput("ld_sel1", memselect_out, 1);
        checkOutput("ld_en1", memenable_out, 1);
        checkOutput("ld_stall2", stall_out, 0);
        checkOutput("ld_addr_held", memaddr_out, 6'h25);
        tick();
        applyStimulus(16'h1314, 32'h10A, 1'b1, 1'b0);
        checkOutput("ld_sel2", memselect_out, 1);
        checkOutput("ld_en2", memenable_out, 1);
        checkOutput("ld_pc_held", pc_out, 32'h108);
        checkOutput("ld_stall3", stall_out, 0);
        tick();
        checkOutput("ld_sel3", memselect_out, 0);
        checkOutput("ld_en3", memenable_out, 0);
        checkOutput("ld_next_op", op_out, 2'b00);
        checkOutput("ld_next_pc", pc_out, 32'h10A);

        // Same-cycle bypass into rs = 5.
        applyStimulus(16'h2800, 32'h10C, 1'b1, 1'b0);
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        tick();
        checkOutput("byp_reg1", reg1data_out, 16'hBEEF);
        // Writes to r0 are discarded; rt = 5 shows the previous write landed.
        applyStimulus(16'h0500, 32'h10E, 1'b1, 1'b0);
        wb_addr = 3'd0; wb_data = 16'h5555;
        tick();
        checkOutput("r0_bypass", reg1data_out, 0);
        checkOutput("r5_stored", reg2data_out, 16'hBEEF);
        wb_en = 1'b0;
        tick();
        checkOutput("r0_after_write", reg1data_out, 0);

        // Flush in RUN gives a bubble; also load r4 for the store below.
        applyStimulus(16'h1314, 32'h110, 1'b1, 1'b1);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'hCAFE;
        tick();
        wb_en = 1'b0;
        checkOutput("fl_valid", valid_out, 0);
        checkOutput("fl_op", op_out, 2'b11);
        checkOutput("fl_funct", funct_out, 3'b111);
        checkOutput("fl_reg1", reg1data_out, 0);

        // Store, flushed during SETUP and ACCESS: must still complete.
        applyStimulus(16'h633A, 32'h112, 1'b1, 1'b0);
        checkOutput("st_stall0", stall_out, 1);
        tick();
        checkOutput("st_pwrite0", datamemwrite_out, 1);
        checkOutput("st_memwrite", memwrite_out, 1);
        checkOutput("st_sel0", memselect_out, 1);
        checkOutput("st_en0", memenable_out, 0);
        checkOutput("st_memaddr", memaddr_out, 6'h3A);
        checkOutput("st_data", reg1data_out, 16'hCAFE);
        applyStimulus(16'h633A, 32'h112, 1'b1, 1'b1);
        tick();
        checkOutput("st_pwrite1", datamemwrite_out, 1);
        checkOutput("st_en1", memenable_out, 1);
        checkOutput("st_valid1", valid_out, 1);
        checkOutput("st_stall2", stall_out, 0);
        tick();
        checkOutput("st_pwrite2", datamemwrite_out, 1);
        checkOutput("st_sel2", memselect_out, 1);
        checkOutput("st_en2", memenable_out, 1);
        applyStimulus(16'h1314, 32'h114, 1'b1, 1'b0);
        tick();
        checkOutput("st_pwrite3", datamemwrite_out, 0);
        checkOutput("st_sel3", memselect_out, 0);
        checkOutput("st_after_valid", valid_out, 1);

        // Jump register: funct 001, rs 5, target 0x7C.
        applyStimulus(16'hCD7C, 32'h116, 1'b1, 1'b0);
        tick();
        checkOutput("j_jmp", jmp_out, 1);
        checkOutput("j_jr", jr_out, 1);
        checkOutput("j_funct", funct_out, 3'b001);
        checkOutput("j_target", jtarget_out, 8'h7C);
        checkOutput("j_reg1", reg1data_out, 16'hBEEF);
        checkOutput("j_rd", rd_out, 0);
        checkOutput("j_op", op_out, 2'b11);

        // Branch-not-equal: rs 2, rt 3, offset 0x15.
        applyStimulus(16'h9335, 32'h118, 1'b1, 1'b0);
        tick();
        checkOutput("b_bne", bne_out, 1);
        checkOutput("b_boffset", boffset_out, 5'h15);
        checkOutput("b_reg1", reg1data_out, 16'h1234);
        checkOutput("b_reg2", reg2data_out, 16'h00FF);
        checkOutput("b_jmp", jmp_out, 0);
        checkOutput("b_rd", rd_out, 0);

        applyStimulus(16'h1314, 32'h11A, 1'b0, 1'b0);
        tick();
        checkOutput("inv_valid", valid_out, 0);
        checkOutput("inv_pc", pc_out, 0);

        // Reset during SETUP aborts the access and clears the register file.
        applyStimulus(16'h4A25, 32'h11C, 1'b1, 1'b0);
        tick();
        checkOutput("ra_sel_setup", memselect_out, 1);
        rst = 1'b0;
        tick();
        checkOutput("ra_sel", memselect_out, 0);
        checkOutput("ra_en", memenable_out, 0);
        checkOutput("ra_valid", valid_out, 0);
        checkOutput("ra_stall", stall_out, 0);
        rst = 1'b1;
        applyStimulus(16'h2000, 32'h11E, 1'b1, 1'b0);
        checkOutput("ra_run_stall", stall_out, 0);
        tick();
        checkOutput("ra_r4_cleared", reg1data_out, 0);
        checkOutput("ra_run_valid", valid_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
